uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds byte bursts from several
// requesters into a single UART transmitter, one frame at a time.
// Optional build macro UART_ARB_TAG_EN prefixes every burst with a tag frame
// (TAG_BASE | grant index) so the receiver can tell which requester follows.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] TAG_BASE = 8'hF0,
  localparam int        GW       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 active
);

  typedef enum logic [2:0] {
    ARB     = 3'd0,
    FETCH   = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
`ifdef UART_ARB_TAG_EN
    , TAG   = 3'd5
`endif
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [GW-1:0] pointer;
  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  logic          found;
  logic          last_flag;
  logic          grant_load;
  logic          fetch_load;

  // Round-robin search: walk from pointer+1 with wrap, first valid requester wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = pointer;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // State register; reset drops any burst in flight back to arbitration
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= next_state;
  end

  // Next-state and strobe decode; tx_start only ever comes from TAG or SEND
  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    req_ready  = '0;
    grant_load = 1'b0;
    fetch_load = 1'b0;
    active     = (state != ARB);
    case (state)
      ARB: begin
        if (!tx_busy && found) begin
          grant_load = 1'b1;
`ifdef UART_ARB_TAG_EN
          next_state = TAG;
`else
          next_state = FETCH;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        tx_start   = 1'b1;
        next_state = WAIT_HI;
      end
`endif
      FETCH: begin
        req_ready[grant_id] = req_valid[grant_id];
        if (req_valid[grant_id]) begin
          fetch_load = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        tx_start   = 1'b1;
        next_state = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) next_state = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) next_state = last_flag ? ARB : FETCH;
      end
      default: next_state = ARB;
    endcase
  end

  // Grant, byte and last-flag registers; the tag byte is loaded at grant time so
  // tx_data is already stable when TAG pulses tx_start, and clearing the last
  // flag on grant makes the tag frame fall through to FETCH afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer   <= GW'(NUM_REQ - 1);
      grant_id  <= '0;
      tx_data   <= 8'h00;
      last_flag <= 1'b0;
    end else begin
      if (grant_load) begin
        pointer   <= pick;
        grant_id  <= pick;
        last_flag <= 1'b0;
`ifdef UART_ARB_TAG_EN
        tx_data   <= TAG_BASE | {5'b00000, 3'(pick)};
`endif
      end
      if (fetch_load) begin
        tx_data   <= req_data[{grant_id, 3'b000} +: 8];
        last_flag <= req_last[grant_id];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter. Requester queues
// feed the DUT, a transmitter model answers tx_start with a busy window, and
// every launched frame is compared against the expected-frame queue.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [1:0]           grant_id;
  logic                 active;

  typedef struct packed {logic [7:0] data; logic last;} beat_t;
  typedef struct packed {logic [7:0] data; logic [1:0] grant;} frame_t;

  beat_t  rq [NUM_REQ][$];
  frame_t sb [$];
  int     checks = 0;
  int     errors = 0;
  int     starts = 0;
  int     busy_cnt = 0;
  bit     auto_tx = 1'b1;
  logic   manual_busy = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TAG_BASE(8'hF0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id), .active(active)
  );

  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task applyStimulus(input int r, input logic [7:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.last = last;
    rq[r].push_back(b);
  endtask

  task expectFrame(input logic [7:0] d, input int g);
    frame_t f;
    f.data  = d;
    f.grant = 2'(g);
    sb.push_back(f);
  endtask

  task expectTag(input int g);
`ifdef UART_ARB_TAG_EN
    expectFrame(8'hF0 | 8'(g), g);
`else
    if (g < 0) $display("[TB] negative requester index");
`endif
  endtask

  function automatic bit allEmpty();
    for (int i = 0; i < NUM_REQ; i++)
      if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task doReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task waitIdle(input string tag);
    int n;
    n = 0;
    while (n < 3000 && !(sb.size() == 0 && allEmpty() && active == 1'b0 && tx_busy == 1'b0)) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n >= 3000), 0);
    checkOutput({tag, "_sb_left"}, sb.size(), 0);
  endtask

  task waitSbEmpty(input string tag);
    int n;
    n = 0;
    while (n < 500 && sb.size() != 0) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(n >= 500), 0);
  endtask

  // Requester model: present queue heads on the falling edge, retire accepted beats
  initial begin
    logic [NUM_REQ-1:0] pending;
    pending   = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++)
        if (pending[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][0].data;
          req_last[i]        = rq[i][0].last;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      #1;
      pending = req_ready & req_valid;
    end
  end

  // Transmitter model and scoreboard check on every launched frame
  initial begin
    frame_t f;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        starts++;
        checkOutput("start_while_busy", 32'(tx_busy), 0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_start", 1, 0);
        end else begin
          f = sb.pop_front();
          checkOutput("tx_data", tx_data, f.data);
          checkOutput("grant_id", grant_id, f.grant);
        end
        busy_cnt = 6;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy = auto_tx ? (busy_cnt > 0 && busy_cnt <= 4) : manual_busy;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    tick(3);
    checkOutput("rst_tx_start", 32'(tx_start), 0);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_active", 32'(active), 0);
    checkOutput("rst_grant_id", grant_id, 0);
    reset = 1'b0;
    tick(1);

    // Two single-byte bursts: requester 0 first after reset, then 2
    expectTag(0); expectFrame(8'hA5, 0);
    expectTag(2); expectFrame(8'h3C, 2);
    applyStimulus(0, 8'hA5, 1'b1);
    applyStimulus(2, 8'h3C, 1'b1);
    waitIdle("pair");

    // Three-byte burst holds the grant against a competing requester
    doReset();
    expectTag(1); expectFrame(8'h11, 1); expectFrame(8'h22, 1); expectFrame(8'h33, 1);
    expectTag(3); expectFrame(8'h44, 3);
    applyStimulus(1, 8'h11, 1'b0);
    applyStimulus(1, 8'h22, 1'b0);
    applyStimulus(1, 8'h33, 1'b1);
    applyStimulus(3, 8'h44, 1'b1);
    waitIdle("burst");

    // Everyone requesting: order 0,1,2,3,0
    doReset();
    expectTag(0); expectFrame(8'h10, 0);
    expectTag(1); expectFrame(8'h11, 1);
    expectTag(2); expectFrame(8'h12, 2);
    expectTag(3); expectFrame(8'h13, 3);
    expectTag(0); expectFrame(8'h20, 0);
    applyStimulus(0, 8'h10, 1'b1);
    applyStimulus(0, 8'h20, 1'b1);
    applyStimulus(1, 8'h11, 1'b1);
    applyStimulus(2, 8'h12, 1'b1);
    applyStimulus(3, 8'h13, 1'b1);
    waitIdle("fair");

    // Granted requester stalls mid-burst; requester 2 must wait
    doReset();
    expectTag(1); expectFrame(8'h55, 1);
    applyStimulus(1, 8'h55, 1'b0);
    applyStimulus(2, 8'h77, 1'b1);
    waitSbEmpty("stall_first");
    tick(30);
    s0 = starts;
    tick(20);
    checkOutput("stall_no_start", starts, s0);
    checkOutput("stall_grant", grant_id, 1);
    checkOutput("stall_active", 32'(active), 1);
    checkOutput("stall_ready", req_ready, 0);
    expectFrame(8'h66, 1);
    expectTag(2); expectFrame(8'h77, 2);
    applyStimulus(1, 8'h66, 1'b1);
    waitIdle("stall");

    // Reset while the transmitter is still busy: nothing launches until it idles
    doReset();
    expectTag(0); expectFrame(8'h99, 0);
    applyStimulus(0, 8'h99, 1'b1);
    waitSbEmpty("rst_first");
    manual_busy = 1'b1;
    auto_tx = 1'b0;
    tick(4);
    expectTag(1); expectFrame(8'hAB, 1);
    applyStimulus(1, 8'hAB, 1'b1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    s0 = starts;
    tick(20);
    checkOutput("rst_busy_no_start", starts, s0);
    checkOutput("rst_busy_active", 32'(active), 0);
    manual_busy = 1'b0;
    auto_tx = 1'b1;
    waitIdle("rst_busy");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
